// File: rtl/cpu_pkg.sv
// Shared CPU-wide register-file geometry and writeback-source encoding.
package cpu_pkg;

    localparam int REG_AW = 5;
    localparam int REG_DW = 32;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_LSU = 2'd1,
        WB_MDU = 2'd2
    } wb_src_e;

    localparam int N_WB_SRC = 3;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr, wrapping.
module rr_arbiter #(
    parameter int N  = 3,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    always_comb begin
        int   j;
        logic found;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            // ptr is always < N, so a single subtraction implements the wrap
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (!found && req[j]) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                idx    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/rf_wport_arbiter.sv
// Round-robin share of the single regfile write port among writeback sources,
// with a registered output stage that also feeds decode-stage bypassing.
module rf_wport_arbiter
    import cpu_pkg::*;
#(
    parameter int N_REQ = 3,
    parameter int AW    = REG_AW,
    parameter int DW    = REG_DW,
    parameter int CNT_W = 16,
    localparam int IW   = $clog2(N_REQ)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_REQ-1:0]    req_valid,
    output logic [N_REQ-1:0]    req_ready,
    input  logic [N_REQ*AW-1:0] req_addr,
    input  logic [N_REQ*DW-1:0] req_data,
    input  logic                hold,
    output logic                rf_we,
    output logic [AW-1:0]       rf_wR,
    output logic [DW-1:0]       rf_wD,
    output logic [IW-1:0]       grant_id,
    output logic [CNT_W-1:0]    conflict_cnt
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [IW-1:0] wrap_next(input logic [IW-1:0] i);
        return (i == IW'(N_REQ - 1)) ? '0 : i + IW'(1);
    endfunction

    logic [IW-1:0]    rr_ptr;
    logic [N_REQ-1:0] arb_req;
    logic [N_REQ-1:0] gnt_p0;
    logic [IW-1:0]    gnt_idx_p0;
    logic             hs_p0;
    logic [AW-1:0]    addr_p0;
    logic [DW-1:0]    data_p0;
    logic             multi_req_p0;

    logic             vld_p1;
    logic [AW-1:0]    addr_p1;
    logic [DW-1:0]    data_p1;
    logic [IW-1:0]    gid_p1;
    logic [CNT_W-1:0] cnt_q;

    // Stage p0: arbitration and source select (combinational)
    assign arb_req = hold ? '0 : req_valid;

    rr_arbiter #(.N(N_REQ)) u_rr (
        .req (arb_req),
        .ptr (rr_ptr),
        .gnt (gnt_p0),
        .idx (gnt_idx_p0)
    );

    assign req_ready = gnt_p0;
    assign hs_p0     = |gnt_p0;

    // gnt is one-hot, so an AND-OR mux is sufficient
    always_comb begin
        addr_p0 = '0;
        data_p0 = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_p0[i]) begin
                addr_p0 = addr_p0 | req_addr[i*AW +: AW];
                data_p0 = data_p0 | req_data[i*DW +: DW];
            end
        end
    end

    assign multi_req_p0 = ($countones(req_valid) > 1) && !hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (hs_p0)        rr_ptr <= wrap_next(gnt_idx_p0);
            if (multi_req_p0) cnt_q  <= sat_inc(cnt_q);
        end
    end

    // Stage p1: registered write port; x0 writes are consumed without asserting we
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            addr_p1 <= '0;
            data_p1 <= '0;
            gid_p1  <= '0;
        end else begin
            vld_p1 <= hs_p0 && (addr_p0 != '0);
            if (hs_p0) begin
                addr_p1 <= addr_p0;
                data_p1 <= data_p0;
                gid_p1  <= gnt_idx_p0;
            end
        end
    end

    assign rf_we        = vld_p1;
    assign rf_wR        = addr_p1;
    assign rf_wD        = data_p1;
    assign grant_id     = gid_p1;
    assign conflict_cnt = cnt_q;

endmodule
